// File: rtl/fetch_if.sv
// Fetch-queue head port between the fetch unit and decode.
// The fetch side drives the head bundle and occupancy; decode returns ready.
interface fetch_if #(
    parameter int AW = 32,
    parameter int FW = 2,
    parameter int CW = 3
);
    logic                  fq_valid;
    logic                  fq_ready;
    logic [FW-1:0][31:0]   fq_inst;
    logic [AW-1:0]         fq_pc;
    logic [CW-1:0]         fq_count;

    modport master (output fq_valid, fq_inst, fq_pc, fq_count, input fq_ready);
    modport slave  (input fq_valid, fq_inst, fq_pc, fq_count, output fq_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures combinational memory bundles into
// a small FIFO drained by decode, and supports redirect/flush.
module fetch_unit #(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         FETCH_WIDTH     = 2,
    parameter int                         FQ_DEPTH        = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fetch_en,
    output logic [INST_ADDR_WIDTH-1:0]         PC,
    input  logic [FETCH_WIDTH-1:0][31:0]       Instruction_Code,
    input  logic                               redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0]         redirect_pc,
    fetch_if.master                            fq
);
    localparam int AW = INST_ADDR_WIDTH;
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [FETCH_WIDTH-1:0][31:0] bundle_t;

    bundle_t       inst_q [FQ_DEPTH];
    logic [AW-1:0] pc_q   [FQ_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push;

    // Head outputs come straight from storage so fq_ready never reaches them.
    assign fq.fq_valid = (count != '0);
    assign fq.fq_inst  = inst_q[rd_ptr];
    assign fq.fq_pc    = pc_q[rd_ptr];
    assign fq.fq_count = count;

    assign full = (count == CW'(FQ_DEPTH));
    assign pop  = fq.fq_valid & fq.fq_ready;
    assign push = fetch_en & ~redirect_valid & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop or fetch.
            PC     <= {redirect_pc[AW-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_q[wr_ptr] <= Instruction_Code;
                pc_q[wr_ptr]   <= PC;
                wr_ptr         <= wr_ptr + 1'b1;
                PC             <= PC + AW'(4 * FETCH_WIDTH);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a queue-based model.
module tb_fetch_unit;
    localparam int AW    = 10;
    localparam int FW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] RPC = '0;

    typedef logic [FW-1:0][31:0] bundle_t;
    typedef struct packed { logic [AW-1:0] pc; bundle_t inst; } ent_t;

    logic          clk = 0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] PC;
    bundle_t       Instruction_Code;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    fetch_if #(.AW(AW), .FW(FW), .CW(CW)) fq_bus ();

    fetch_unit #(.INST_ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .PC(PC),
        .Instruction_Code(Instruction_Code), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fq(fq_bus)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address a is 0x13 + a/4.
    function automatic bundle_t mem_bundle(input logic [AW-1:0] pc);
        bundle_t b;
        for (int k = 0; k < FW; k++) begin
            logic [AW-1:0] a;
            a    = pc + AW'(4 * k);
            b[k] = 32'h13 + 32'(a >> 2);
        end
        return b;
    endfunction

    assign Instruction_Code = mem_bundle(PC);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {pc, bundle} plus the fetch address.
    ent_t          q[$];
    logic [AW-1:0] m_pc = RPC;
    bit            m_pop, m_push;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_pc = RPC;
        end else begin
            m_pop  = (q.size() > 0) && fq_bus.fq_ready;
            m_push = fetch_en && !redirect_valid && ((q.size() < DEPTH) || m_pop);
            if (redirect_valid) begin
                q.delete();
                m_pc = {redirect_pc[AW-1:2], 2'b00};
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    q.push_back('{pc: m_pc, inst: mem_bundle(m_pc)});
                    m_pc = m_pc + AW'(4 * FW);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("model_pc", 64'(PC), 64'(m_pc));
            chk("model_valid", 64'(fq_bus.fq_valid), 64'(q.size() != 0));
            chk("model_count", 64'(fq_bus.fq_count), 64'(q.size()));
            if (q.size() != 0) begin
                chk("model_fq_pc", 64'(fq_bus.fq_pc), 64'(q[0].pc));
                chk("model_fq_inst", 64'(fq_bus.fq_inst), 64'(q[0].inst));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 0; fetch_en = 0; fq_bus.fq_ready = 0; redirect_valid = 0;
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset = 1; fetch_en = 0; fq_bus.fq_ready = 0; redirect_valid = 0; redirect_pc = '0;
        #1 reset = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(fq_bus.fq_valid), 64'd0);
        chk("rst_count", 64'(fq_bus.fq_count), 64'd0);
        chk("rst_fq_pc", 64'(fq_bus.fq_pc), 64'd0);
        chk("rst_fq_inst", 64'(fq_bus.fq_inst), 64'd0);
        chk("rst_pc", 64'(PC), 64'd0);

        // Streaming fetch with decode always ready.
        reset = 1; fetch_en = 1; fq_bus.fq_ready = 1;
        @(negedge clk);
        chk("stream_fq_pc0", 64'(fq_bus.fq_pc), 64'h0);
        chk("stream_inst1", 64'(fq_bus.fq_inst[1]), 64'h14);
        chk("stream_pc", 64'(PC), 64'h8);
        @(negedge clk);
        chk("stream_fq_pc8", 64'(fq_bus.fq_pc), 64'h8);
        @(negedge clk);
        chk("stream_fq_pc16", 64'(fq_bus.fq_pc), 64'h10);

        // Fill to full with decode stalled, then drain through the full boundary.
        do_reset();
        fetch_en = 1;
        repeat (4) @(negedge clk);
        chk("full_count", 64'(fq_bus.fq_count), 64'd4);
        chk("full_pc", 64'(PC), 64'd32);
        @(negedge clk);
        chk("full_pc_hold", 64'(PC), 64'd32);
        fq_bus.fq_ready = 1;
        for (int e = 0; e < 5; e++) begin
            chk("full_drain_fq_pc", 64'(fq_bus.fq_pc), 64'(8 * e));
            @(negedge clk);
        end

        // Redirect with three entries queued and decode ready.
        do_reset();
        fetch_en = 1;
        repeat (3) @(negedge clk);
        chk("redir_pre_count", 64'(fq_bus.fq_count), 64'd3);
        fq_bus.fq_ready = 1; redirect_valid = 1; redirect_pc = 10'h0A7;
        @(negedge clk);
        redirect_valid = 0;
        chk("redir_valid", 64'(fq_bus.fq_valid), 64'd0);
        chk("redir_count", 64'(fq_bus.fq_count), 64'd0);
        chk("redir_pc", 64'(PC), 64'h0A4);
        @(negedge clk);
        chk("redir_fq_pc", 64'(fq_bus.fq_pc), 64'h0A4);

        // PC wrap at the top of the address space.
        redirect_valid = 1; redirect_pc = 10'h3F8;
        @(negedge clk);
        redirect_valid = 0;
        @(negedge clk);
        chk("wrap_fq_pc_hi", 64'(fq_bus.fq_pc), 64'h3F8);
        chk("wrap_pc", 64'(PC), 64'h000);
        @(negedge clk);
        chk("wrap_fq_pc_lo", 64'(fq_bus.fq_pc), 64'h000);

        // Fetch disabled: queue drains, PC holds.
        fq_bus.fq_ready = 0; redirect_valid = 1; redirect_pc = 10'h100;
        @(negedge clk);
        redirect_valid = 0;
        repeat (2) @(negedge clk);
        chk("drain_pre_count", 64'(fq_bus.fq_count), 64'd2);
        chk("drain_pre_pc", 64'(PC), 64'h110);
        fetch_en = 0; fq_bus.fq_ready = 1;
        @(negedge clk);
        chk("drain_count1", 64'(fq_bus.fq_count), 64'd1);
        @(negedge clk);
        chk("drain_count0", 64'(fq_bus.fq_count), 64'd0);
        chk("drain_pc", 64'(PC), 64'h110);

        // Asynchronous reset between clock edges.
        fetch_en = 1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("async_valid", 64'(fq_bus.fq_valid), 64'd0);
        chk("async_pc", 64'(PC), 64'(RPC));
        chk("async_count", 64'(fq_bus.fq_count), 64'd0);
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        chk("async_resume_fq_pc", 64'(fq_bus.fq_pc), 64'h10);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            fetch_en        = ($urandom % 10) < 8;
            fq_bus.fq_ready = ($urandom % 10) < 6;
            redirect_valid  = ($urandom % 20) == 0;
            redirect_pc     = AW'($urandom_range(0, 1023));
        end
        @(negedge clk);
        redirect_valid = 0; fetch_en = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
